// File: rtl/jaa_translator.sv
// Streaming Java-bytecode to ARM translator: fetches bytecodes/operands from a
// synchronous byte ROM and emits AL-condition ARM words on a valid/ready stream.
module jaa_translator #(
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned START_ADDR  = 0,
    parameter int unsigned LOCAL_SHIFT = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [7:0]            rom_data_i,
    output logic [31:0]           instr_out_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int unsigned OFF_WIDTH = 12;
    localparam logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] PC_LAST  = {ADDR_WIDTH{1'b1}};

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_ICONST0 = 8'h03;
    localparam logic [7:0] OP_ICONST5 = 8'h08;
    localparam logic [7:0] OP_BIPUSH  = 8'h10;
    localparam logic [7:0] OP_SIPUSH  = 8'h11;
    localparam logic [7:0] OP_ILOAD   = 8'h15;
    localparam logic [7:0] OP_ILOAD0  = 8'h1A;
    localparam logic [7:0] OP_ILOAD3  = 8'h1D;
    localparam logic [7:0] OP_ISTORE  = 8'h36;
    localparam logic [7:0] OP_ISTORE0 = 8'h3B;
    localparam logic [7:0] OP_ISTORE3 = 8'h3E;
    localparam logic [7:0] OP_IADD    = 8'h60;
    localparam logic [7:0] OP_ISUB    = 8'h64;
    localparam logic [7:0] OP_RETURN  = 8'hB1;

    localparam logic [31:0] W_MOV   = 32'hE3A01000;
    localparam logic [31:0] W_MOVHI = 32'hE3A01C00;
    localparam logic [31:0] W_ORR   = 32'hE3811000;
    localparam logic [31:0] W_PUSH  = 32'hE92D0002;
    localparam logic [31:0] W_POP1  = 32'hE8BD0002;
    localparam logic [31:0] W_POP2  = 32'hE8BD0006;
    localparam logic [31:0] W_LDR   = 32'hE5931000;
    localparam logic [31:0] W_STR   = 32'hE5831000;
    localparam logic [31:0] W_ADD   = 32'hE0811002;
    localparam logic [31:0] W_SUB   = 32'hE0421001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_EMIT,
        S_HALT
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   wrap_q, wrap_d;
    logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
    logic [7:0]             opcode_q, opcode_d;
    logic [7:0]             hi_q, hi_d;
    logic [1:0]             opnd_cnt_q, opnd_cnt_d;
    logic [3:0][31:0]       word_q, word_d;
    logic [1:0]             nwords_q, nwords_d;
    logic [1:0]             widx_q, widx_d;
    logic [31:0]            instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic [7:0]             dec_op;
    logic [3:0][31:0]       dec_w;
    logic [1:0]             dec_n;
    logic                   dec_ret;
    logic                   dec_err;

    logic                   go_fetch;
    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic                   fetch_wrap;

    // Local-slot byte offset, zero-extended to the 12-bit immediate field.
    function automatic logic [31:0] slot_off(input logic [7:0] idx);
        return 32'(OFF_WIDTH'(idx) << LOCAL_SHIFT);
    endfunction

    // Opcode decode; the last byte of an instruction is still on rom_data_i.
    always_comb begin
        dec_op  = (opnd_cnt_q == 2'd0) ? rom_data_i : opcode_q;
        dec_w   = '0;
        dec_n   = 2'd0;
        dec_ret = 1'b0;
        dec_err = 1'b0;
        case (dec_op) inside
            OP_NOP: ;
            [OP_ICONST0:OP_ICONST5]: begin
                dec_w[0] = W_MOV | 32'(dec_op - OP_ICONST0);
                dec_w[1] = W_PUSH;
                dec_n    = 2'd2;
            end
            OP_BIPUSH: begin
                dec_w[0] = W_MOV | 32'(rom_data_i);
                dec_w[1] = W_PUSH;
                dec_n    = 2'd2;
            end
            OP_SIPUSH: begin
                dec_w[0] = W_MOVHI | 32'(hi_q);
                dec_w[1] = W_ORR | 32'(rom_data_i);
                dec_w[2] = W_PUSH;
                dec_n    = 2'd3;
            end
            OP_ILOAD, [OP_ILOAD0:OP_ILOAD3]: begin
                dec_w[0] = W_LDR | slot_off((dec_op == OP_ILOAD) ? rom_data_i
                                                                  : dec_op - OP_ILOAD0);
                dec_w[1] = W_PUSH;
                dec_n    = 2'd2;
            end
            OP_ISTORE, [OP_ISTORE0:OP_ISTORE3]: begin
                dec_w[0] = W_POP1;
                dec_w[1] = W_STR | slot_off((dec_op == OP_ISTORE) ? rom_data_i
                                                                   : dec_op - OP_ISTORE0);
                dec_n    = 2'd2;
            end
            OP_IADD: begin
                dec_w[0] = W_POP2;
                dec_w[1] = W_ADD;
                dec_w[2] = W_PUSH;
                dec_n    = 2'd3;
            end
            OP_ISUB: begin
                dec_w[0] = W_POP2;
                dec_w[1] = W_SUB;
                dec_w[2] = W_PUSH;
                dec_n    = 2'd3;
            end
            OP_RETURN: dec_ret = 1'b1;
            default:   dec_err = 1'b1;
        endcase
    end

    // Next-state and output logic; every FETCH entry presents rom_addr on the same edge.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wrap_d     = wrap_q;
        rom_addr_d = rom_addr_q;
        opcode_d   = opcode_q;
        hi_d       = hi_q;
        opnd_cnt_d = opnd_cnt_q;
        word_d     = word_q;
        nwords_d   = nwords_q;
        widx_d     = widx_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        done_d     = done_q;
        error_d    = error_q;
        go_fetch   = 1'b0;
        fetch_pc   = pc_q;
        fetch_wrap = wrap_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start_i) begin
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    opnd_cnt_d = 2'd0;
                    go_fetch   = 1'b1;
                    fetch_pc   = START_PC;
                    fetch_wrap = 1'b0;
                end
            end
            S_FETCH: state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (opnd_cnt_q == 2'd0) begin
                    opcode_d = rom_data_i;
                end
                if (opnd_cnt_q == 2'd0 && (rom_data_i == OP_BIPUSH || rom_data_i == OP_ILOAD ||
                                           rom_data_i == OP_ISTORE)) begin
                    opnd_cnt_d = 2'd1;
                    go_fetch   = 1'b1;
                end else if (opnd_cnt_q == 2'd0 && rom_data_i == OP_SIPUSH) begin
                    opnd_cnt_d = 2'd2;
                    go_fetch   = 1'b1;
                end else if (opnd_cnt_q == 2'd2) begin
                    hi_d       = rom_data_i;
                    opnd_cnt_d = 2'd1;
                    go_fetch   = 1'b1;
                end else begin
                    opnd_cnt_d = 2'd0;
                    if (dec_err) begin
                        error_d = 1'b1;
                        state_d = S_HALT;
                    end else if (dec_ret) begin
                        done_d  = 1'b1;
                        state_d = S_HALT;
                    end else if (dec_n == 2'd0) begin
                        go_fetch = 1'b1;
                    end else begin
                        word_d   = dec_w;
                        nwords_d = dec_n;
                        instr_d  = dec_w[0];
                        valid_d  = 1'b1;
                        widx_d   = 2'd1;
                        state_d  = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (instr_ready_i) begin
                    if (widx_q == nwords_q) begin
                        valid_d  = 1'b0;
                        go_fetch = 1'b1;
                    end else begin
                        instr_d = word_q[widx_q];
                        widx_d  = widx_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A fetch after the pc has wrapped is an error instead of a fetch.
        if (go_fetch) begin
            if (fetch_wrap) begin
                state_d = S_HALT;
                error_d = 1'b1;
            end else begin
                state_d    = S_FETCH;
                rom_addr_d = fetch_pc;
                pc_d       = fetch_pc + ADDR_WIDTH'(1);
                wrap_d     = (fetch_pc == PC_LAST);
            end
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pc_q       <= START_PC;
            wrap_q     <= 1'b0;
            rom_addr_q <= '0;
            opcode_q   <= '0;
            hi_q       <= '0;
            opnd_cnt_q <= '0;
            word_q     <= '0;
            nwords_q   <= '0;
            widx_q     <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wrap_q     <= wrap_d;
            rom_addr_q <= rom_addr_d;
            opcode_q   <= opcode_d;
            hi_q       <= hi_d;
            opnd_cnt_q <= opnd_cnt_d;
            word_q     <= word_d;
            nwords_q   <= nwords_d;
            widx_q     <= widx_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign rom_addr_o    = rom_addr_q;
    assign instr_out_o   = instr_q;
    assign instr_valid_o = valid_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_jaa_translator.sv
// Bench for jaa_translator: directed vector table, timing/backpressure/wrap/reset
// sequences, and random programs checked against a bytecode interpreter model.
module tb_jaa_translator;

    localparam int unsigned AW       = 6;
    localparam int unsigned ROM_SIZE = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start3;
    logic [AW-1:0] rom_addr, rom_addr3;
    logic [7:0]  rom_data, rom_data3;
    logic [31:0] instr, instr3;
    logic        valid, valid3;
    logic        ready, ready3;
    logic        busy, busy3, done, done3, error, error3;

    logic [7:0]  rom [ROM_SIZE];
    logic [31:0] got [$];
    logic [31:0] got3 [$];
    logic [31:0] exp_q [$];
    bit          exp_done, exp_err;

    bit          rand_ready;
    logic        ready_man;
    logic        rnd_bit;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    jaa_translator #(.ADDR_WIDTH(AW), .START_ADDR(0), .LOCAL_SHIFT(2)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .rom_addr_o(rom_addr),
        .rom_data_i(rom_data), .instr_out_o(instr), .instr_valid_o(valid),
        .instr_ready_i(ready), .busy_o(busy), .done_o(done), .error_o(error)
    );

    jaa_translator #(.ADDR_WIDTH(AW), .START_ADDR(0), .LOCAL_SHIFT(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start3), .rom_addr_o(rom_addr3),
        .rom_data_i(rom_data3), .instr_out_o(instr3), .instr_valid_o(valid3),
        .instr_ready_i(ready3), .busy_o(busy3), .done_o(done3), .error_o(error3)
    );

    always @(posedge clk) begin
        rom_data  <= rom[rom_addr];
        rom_data3 <= rom[rom_addr3];
    end

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end
    assign ready = rand_ready ? rnd_bit : ready_man;

    always @(negedge clk) begin
        if (!rst && valid && ready)   got.push_back(instr);
        if (!rst && valid3 && ready3) got3.push_back(instr3);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Bytecode interpreter: walks the ROM image and lists the ARM words it should yield.
    int m_pc;
    bit m_wrap;

    function automatic bit m_get(output logic [7:0] b);
        b = 8'h00;
        if (m_wrap) return 1'b0;
        b    = rom[m_pc];
        m_pc = m_pc + 1;
        if (m_pc == ROM_SIZE) begin
            m_pc   = 0;
            m_wrap = 1'b1;
        end
        return 1'b1;
    endfunction

    task automatic model_run(input int shift);
        logic [7:0] op, a, b;
        int idx, val;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        m_pc     = 0;
        m_wrap   = 1'b0;
        for (int step = 0; step < 200 && !exp_done && !exp_err; step++) begin
            if (!m_get(op)) begin exp_err = 1'b1; break; end
            if (op >= 8'h03 && op <= 8'h08) begin
                exp_q.push_back(32'hE3A01000 + 32'(op - 8'h03));
                exp_q.push_back(32'hE92D0002);
            end else if (op == 8'h10) begin
                if (!m_get(a)) begin exp_err = 1'b1; break; end
                exp_q.push_back(32'hE3A01000 + 32'(a));
                exp_q.push_back(32'hE92D0002);
            end else if (op == 8'h11) begin
                if (!m_get(a)) begin exp_err = 1'b1; break; end
                if (!m_get(b)) begin exp_err = 1'b1; break; end
                val = int'(a) * 256 + int'(b);
                exp_q.push_back(32'hE3A01C00 + 32'(val / 256));
                exp_q.push_back(32'hE3811000 + 32'(val % 256));
                exp_q.push_back(32'hE92D0002);
            end else if (op == 8'h15 || (op >= 8'h1A && op <= 8'h1D)) begin
                if (op == 8'h15) begin
                    if (!m_get(a)) begin exp_err = 1'b1; break; end
                    idx = int'(a);
                end else idx = int'(op) - 'h1A;
                exp_q.push_back(32'hE5931000 + 32'(idx * (1 << shift)));
                exp_q.push_back(32'hE92D0002);
            end else if (op == 8'h36 || (op >= 8'h3B && op <= 8'h3E)) begin
                if (op == 8'h36) begin
                    if (!m_get(a)) begin exp_err = 1'b1; break; end
                    idx = int'(a);
                end else idx = int'(op) - 'h3B;
                exp_q.push_back(32'hE8BD0002);
                exp_q.push_back(32'hE5831000 + 32'(idx * (1 << shift)));
            end else if (op == 8'h60 || op == 8'h64) begin
                exp_q.push_back(32'hE8BD0006);
                exp_q.push_back(op == 8'h60 ? 32'hE0811002 : 32'hE0421001);
                exp_q.push_back(32'hE92D0002);
            end else if (op == 8'hB1) begin
                exp_done = 1'b1;
            end else if (op != 8'h00) begin
                exp_err = 1'b1;
            end
        end
    endtask

    task automatic clear_rom();
        for (int a = 0; a < ROM_SIZE; a++) rom[a] = 8'h00;
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        int cyc = 0;
        while (busy && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_timeout"}, 32'(busy), 32'd0);
    endtask

    // Start a run and compare the stream and final status with exp_q/exp_done/exp_err.
    task automatic run_cmp(input string name);
        int base;
        base = got.size();
        start_pulse();
        check({name, "_clr"}, {30'd0, done, error}, 32'd0);
        wait_halt(name);
        check({name, "_count"}, 32'(got.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < got.size())
                check($sformatf("%s_w%0d", name, i), got[base + i], exp_q[i]);
        check({name, "_done"}, 32'(done), 32'(exp_done));
        check({name, "_error"}, 32'(error), 32'(exp_err));
    endtask

    typedef struct {
        string        name;
        logic [127:0] prog;
        int           np;
        logic [255:0] words;
        int           nw;
        bit           ed;
        bit           ee;
    } vec_t;

    vec_t vecs [8];

    logic [7:0] legal [21] = '{8'h00, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h10,
                               8'h11, 8'h15, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h36, 8'h3B,
                               8'h3C, 8'h3D, 8'h3E, 8'h60, 8'h64};

    initial begin
        int base;
        bit found;

        vecs[0] = '{name:"v_const_store_load", prog:128'h053C1BB1, np:4,
                    words:256'hE3A01002_E92D0002_E8BD0002_E5831004_E5931004_E92D0002,
                    nw:6, ed:1'b1, ee:1'b0};
        vecs[1] = '{name:"v_bipush_sipush_iadd", prog:128'h107F11123460B1, np:7,
                    words:256'hE3A0107F_E92D0002_E3A01C12_E3811034_E92D0002_E8BD0006_E0811002_E92D0002,
                    nw:8, ed:1'b1, ee:1'b0};
        vecs[2] = '{name:"v_iload5", prog:128'h1505B1, np:3,
                    words:256'hE5931014_E92D0002, nw:2, ed:1'b1, ee:1'b0};
        vecs[3] = '{name:"v_bad_op", prog:128'hFF, np:1, words:256'h0, nw:0, ed:1'b0, ee:1'b1};
        vecs[4] = '{name:"v_isub_after_err", prog:128'h070864B1, np:4,
                    words:256'hE3A01004_E92D0002_E3A01005_E92D0002_E8BD0006_E0421001_E92D0002,
                    nw:7, ed:1'b1, ee:1'b0};
        vecs[5] = '{name:"v_istore_ff", prog:128'h0036FF1DB1, np:5,
                    words:256'hE8BD0002_E58313FC_E593100C_E92D0002, nw:4, ed:1'b1, ee:1'b0};
        vecs[6] = '{name:"v_err_after_words", prog:128'h0350, np:2,
                    words:256'hE3A01000_E92D0002, nw:2, ed:1'b0, ee:1'b1};
        vecs[7] = '{name:"v_sipush_max", prog:128'h11FFFFB1, np:4,
                    words:256'hE3A01CFF_E38110FF_E92D0002, nw:3, ed:1'b1, ee:1'b0};

        rst        = 1'b1;
        start      = 1'b0;
        start3     = 1'b0;
        ready3     = 1'b1;
        rand_ready = 1'b0;
        ready_man  = 1'b1;
        clear_rom();
        repeat (3) @(negedge clk);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_flags", {28'd0, valid, busy, done, error}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Directed vectors with ready held high.
        for (int v = 0; v < 8; v++) begin
            clear_rom();
            for (int i = 0; i < vecs[v].np; i++)
                rom[i] = vecs[v].prog[(vecs[v].np - 1 - i) * 8 +: 8];
            exp_q.delete();
            for (int i = 0; i < vecs[v].nw; i++)
                exp_q.push_back(vecs[v].words[(vecs[v].nw - 1 - i) * 32 +: 32]);
            exp_done = vecs[v].ed;
            exp_err  = vecs[v].ee;
            run_cmp(vecs[v].name);
        end

        // First-word latency and a stalled sink on iconst_5.
        clear_rom();
        rom[0] = 8'h08;
        rom[1] = 8'hB1;
        ready_man = 1'b0;
        base = got.size();
        start_pulse();
        @(negedge clk);
        check("t_fetch", {30'd0, 1'(rom_addr == '0), busy}, 32'd3);
        @(negedge clk);
        check("t_no_early_valid", 32'(valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t_stall%0d", i), {valid, instr[30:0]}, {1'b1, 31'h63A01005});
        end
        @(posedge clk); #1 ready_man = 1'b1;
        @(negedge clk);
        check("t_first_xfer", instr, 32'hE3A01005);
        @(negedge clk);
        check("t_second", {valid, instr[30:0]}, {1'b1, 31'h692D0002});
        @(negedge clk);
        check("t_drop", 32'(valid), 32'd0);
        wait_halt("t");
        check("t_count", 32'(got.size() - base), 32'd2);
        if (got.size() - base == 2) begin
            check("t_w0", got[base], 32'hE3A01005);
            check("t_w1", got[base + 1], 32'hE92D0002);
        end
        check("t_done", 32'(done), 32'd1);

        // Address wrap: all nops, then a sipush cut by the wrap, then a word before the wrap.
        clear_rom();
        exp_q.delete(); exp_done = 1'b0; exp_err = 1'b1;
        run_cmp("wrap_nops");
        rom[62] = 8'h11;
        rom[63] = 8'h12;
        run_cmp("wrap_sipush");
        rom[62] = 8'h00;
        rom[63] = 8'h04;
        exp_q.push_back(32'hE3A01001);
        exp_q.push_back(32'hE92D0002);
        run_cmp("wrap_iconst");

        // Offset scaling with LOCAL_SHIFT=3.
        clear_rom();
        rom[0] = 8'h15; rom[1] = 8'h05; rom[2] = 8'hB1;
        @(posedge clk); #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        for (int c = 0; c < 200 && busy3; c++) @(negedge clk);
        check("s3_count", 32'(got3.size()), 32'd2);
        if (got3.size() == 2) begin
            check("s3_w0", got3[0], 32'hE5931028);
            check("s3_w1", got3[1], 32'hE92D0002);
        end
        check("s3_done", {30'd0, done3, busy3}, 32'd2);

        // Asynchronous reset in the middle of iadd emission, then a clean rerun.
        clear_rom();
        rom[0] = 8'h07; rom[1] = 8'h08; rom[2] = 8'h60; rom[3] = 8'hB1;
        start_pulse();
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (valid && instr == 32'hE0811002) found = 1'b1;
        end
        check("r_reached_iadd", 32'(found), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("r_async_instr", instr, 32'd0);
        check("r_async_flags", {27'd0, 1'(rom_addr == '0), valid, busy, done, error}, 32'd16);
        @(posedge clk); #1 rst = 1'b0;
        model_run(2);
        run_cmp("r_rerun");

        // Random programs with random sink backpressure.
        rand_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            for (int a = 0; a < ROM_SIZE; a++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 8)       rom[a] = 8'hB1;
                else if (r < 13) rom[a] = 8'($urandom_range(0, 255));
                else             rom[a] = legal[$urandom_range(0, 20)];
            end
            model_run(2);
            run_cmp($sformatf("rnd%0d", t));
        end
        rand_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/jaa_translator.md
# jaa_translator

Streaming Java-bytecode-to-ARM translator: fetches bytecodes and their operands from an external synchronous byte ROM and emits the equivalent 32-bit ARM (condition AL) instruction words on a valid/ready stream. It generalises the bytecode translator with these additions:
- parametrised program and local-slot addressing;
- operand-carrying bytecodes;
- output backpressure;
- explicit completion and error reporting.

It sits between the program ROM and the ARM instruction sink (result writer or instruction buffer).

## Interface
- ADDR_WIDTH, 6, ROM address width; program wraps at 2^ADDR_WIDTH bytes
- START_ADDR, 0, first bytecode address after start
- LOCAL_SHIFT, 2, local-slot byte offset = index << LOCAL_SHIFT; (255 << LOCAL_SHIFT) must fit in 12 bits
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin translation at START_ADDR; honoured only in IDLE or HALT
- rom_addr  out  ADDR_WIDTH  registered byte address to ROM
- rom_data  in  8  ROM data, valid one cycle after rom_addr
- instr_out  out  32  ARM instruction word
- instr_valid  out  1  instr_out valid
- instr_ready  in  1  sink accepts word when valid&ready
- busy  out  1  high in every state except IDLE/HALT
- done  out  1  sticky; return (0xB1) translated
- error  out  1  sticky; unknown opcode or address wrap

## Operation
- States:
  - IDLE: start → FETCH, pc=START_ADDR.
  - FETCH: drive rom_addr=pc, pc++ → CAPTURE.
  - CAPTURE: latch rom_data as opcode or operand. Operands pending → FETCH, else EMIT (0 words → FETCH).
  - EMIT: one word per handshake; after last accepted word → FETCH.
  - HALT: start → FETCH (clears done/error).
- Registers: R1/R2 scratch, R3 frame base, SP stack. Opcode → words (hex):
  - 0x00 nop: none
  - 0x03–0x08 iconst_n: E3A01000|n ; E92D0002
  - 0x10 bipush b: E3A01000|b ; E92D0002 (b raw, unsigned)
  - 0x11 sipush hi,lo: E3A01C00|hi ; E3811000|lo ; E92D0002 (16-bit unsigned value)
  - 0x15 iload i / 0x1A–0x1D iload_n: E5931000|off ; E92D0002
  - 0x36 istore i / 0x3B–0x3E istore_n: E8BD0002 ; E5831000|off
  - 0x60 iadd: E8BD0006 ; E0811002 ; E92D0002
  - 0x64 isub: E8BD0006 ; E0421001 ; E92D0002
  - 0xB1 return: no words; done=1 → HALT
  - other: error=1, no words → HALT
- Offsets:
  - off = idx << LOCAL_SHIFT, zero-extended to 12 bits.
  - idx = operand byte, or n for the _n forms (n = opcode − 0x1A or − 0x3B).
- Operand bytes are fetched in program order (sipush: hi first).
- Address wrap: a fetch needed with pc wrapped past 2^ADDR_WIDTH−1 back to 0 (not yet halted) → error=1 → HALT, no word emitted.

## Timing
- Reset (async) values:
  - state=IDLE, pc=START_ADDR, rom_addr=0, instr_out=0;
  - instr_valid=0, busy=0, done=0, error=0;
  - instr_valid drops immediately on reset assertion, even mid-emission.
- Each fetched byte costs 2 cycles (FETCH, CAPTURE). With start sampled at edge k and ready held high:
  - rom_addr=START_ADDR in cycle k+1;
  - an iconst first word is valid in cycle k+3, its second word in k+4.
- instr_out and instr_valid are registered. While valid && !ready, instr_out is held stable.
- Each word transfers on a cycle with valid&ready; consecutive words can transfer back-to-back.
- The next FETCH begins the cycle after the last word is accepted.
- start is ignored while busy.
- start in HALT clears done/error on the same edge it enters FETCH.
- done and error are never both set by one run.

## Test plan
- iconst_2, istore_1, iload_1, return at 0..3, ready=1 → E3A01002, E92D0002, E8BD0002, E5831004, E5931004, E92D0002; then done=1, busy=0.
- bipush 0x7F, sipush 0x12 0x34, iadd, return → E3A0107F, E92D0002, E3A01C12, E3811034, E92D0002, E8BD0006, E0811002, E92D0002; done=1.
- iload 0x05 with LOCAL_SHIFT=2 → E5931014. With LOCAL_SHIFT=3 → E5931028.
- iconst_5 with instr_ready low for 4 cycles → instr_out=E3A01005, instr_valid held 4 cycles; no duplicate or lost word.
- Opcode 0xFF at START_ADDR → no valid words, error=1, HALT. A following start with a valid program clears error and translates.
- Reset asserted mid-iadd emission → all outputs return to reset values asynchronously. The next start re-translates from START_ADDR.
